serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer built around one instance of the team's existing full_adder cell (ports A, B, Cin, Sum, Cout). It accepts two WIDTH-bit operands and a carry-in on a start pulse. It then feeds the single full adder one bit pair per clock, LSB first, with a registered carry between bits. It presents the WIDTH-bit sum and carry-out with a one-cycle done strobe. This block trades area for latency and is the reference controller for reusing the 1-bit datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle strobe, result valid
sum  output  WIDTH  result, held until next completion
cout  output  1  final carry-out, held with sum

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Assertion immediately forces state IDLE, busy=0, done=0, sum=0, cout=0, and clears internal operand/carry/counter registers. Deassertion is synchronous to clk in the instantiating design.
- Internal registers:
  - a_sh, b_sh: operand shift registers.
  - s_sh: sum shift register.
  - carry: 1-bit carry register.
  - bit_cnt: counter of width $clog2(WIDTH+1).
- full_adder connections: A=a_sh[0], B=b_sh[0], Cin=carry.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a, b, cin into a_sh, b_sh, carry; clear bit_cnt; go to RUN.
  - start=0: stay in IDLE.
  - sum/cout hold their previous values.
- RUN, each edge:
  - s_sh <= {fa.Sum, s_sh[WIDTH-1:1]}; carry <= fa.Cout; a_sh and b_sh shift right by 1; bit_cnt += 1.
  - When bit_cnt == WIDTH-1 at the edge (last bit): load sum <= {fa.Sum, s_sh[WIDTH-1:1]} and cout <= fa.Cout; go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- busy=1 only in RUN; done=1 only in DONE. Both are decoded from registered state (glitch-free, no combinational path from inputs).
- Latency: with start accepted at edge k, done is high in the cycle after edge k+WIDTH. A new start is accepted at edge k+WIDTH+2 at the earliest. Throughput is one operation per WIDTH+2 cycles.
- sum/cout change only at the edge entering DONE. They are stable throughout RUN and never expose partial results.
- start is ignored in RUN and DONE, and no request is queued. Holding start high continuously yields back-to-back operations, each re-capturing a/b/cin in IDLE.
- a, b, cin are don't-care after capture. Changing them mid-operation has no effect.
- WIDTH=1: RUN lasts one cycle; sum = a^b^cin, cout = majority(a, b, cin).
- Arithmetic: {cout, sum} == a + b + cin, modulo 2^(WIDTH+1). Overflow appears only in cout.
- Reset mid-RUN: operation aborted, no done strobe, outputs cleared to 0.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse at edge k -> busy high for 8 cycles; done high exactly one cycle after edge k+8; sum=8'h00, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0. sum must not change during any RUN.
- WIDTH=8, start held high for 30 cycles with a=8'h01, b=8'h01 -> done strobes at 10-cycle spacing, each with sum=8'h02, cout=0. Changing a/b mid-RUN does not alter the result in flight.
- WIDTH=8, a=8'h80, b=8'h80, start, then rst_n low after 4 RUN cycles -> busy=0, done=0, sum=0, cout=0 immediately (asynchronously). After release with start low, no done strobe appears.
- WIDTH=1, exhaustive {a,b,cin} from 3'b000 to 3'b111, one start per operation -> {cout,sum} = 00,01,01,10,01,10,10,11, matching the full_adder truth table.
- Random self-check, WIDTH=16, 1000 operations -> {cout,sum} == a+b+cin every time; done count equals accepted start count.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared 1-bit full adder, LSB first,
// registered carry between bits, result published only on completion.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one bit pair added per clock
// DONE  | one-cycle done strobe, result valid

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic             busy_o, done_o;

  full_adder fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // The new bit enters at the MSB; the concat/shift form also covers WIDTH=1.
  assign s_next   = WIDTH'({fa_sum, s_sh} >> 1);
  assign last_bit = (bit_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded purely from registered state.
  always_comb begin
    busy_o = (state == RUN);
    done_o = (state == DONE);
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry   <= bus.cin;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          s_sh    <= s_next;
          carry   <= fa_cout;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            sum_q  <= s_next;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: WIDTH 8, 1 and 16 instances against an arithmetic model.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1))  bus1 ();
  serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();

  serial_adder_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_adder_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int total = 0;
  int bad   = 0;
  int done_cnt  [3] = '{0, 0, 0};
  int start_cnt [3] = '{0, 0, 0};

  always @(posedge clk) begin
    if (bus8.done)  done_cnt[0]++;
    if (bus1.done)  done_cnt[1]++;
    if (bus16.done) done_cnt[2]++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wd(input int sel);
    case (sel)
      0: return 8;
      1: return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int sel);
    case (sel)
      0: return 32'(bus8.sum);
      1: return 32'(bus1.sum);
      default: return 32'(bus16.sum);
    endcase
  endfunction

  function automatic logic cout_of(input int sel);
    case (sel)
      0: return bus8.cout;
      1: return bus1.cout;
      default: return bus16.cout;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0: return bus8.busy;
      1: return bus1.busy;
      default: return bus16.busy;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0: return bus8.done;
      1: return bus1.done;
      default: return bus16.done;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic c);
    case (sel)
      0: begin bus8.start = st; bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.cin = c; end
      1: begin bus1.start = st; bus1.a = av[0]; bus1.b = bv[0]; bus1.cin = c; end
      default: begin bus16.start = st; bus16.a = av[15:0]; bus16.b = bv[15:0]; bus16.cin = c; end
    endcase
  endtask

  // One operation from an idle DUT; checks exact latency, sum stability
  // during RUN, and the result against plain integer addition.
  task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input bit scramble, input int gap);
    int          w;
    logic [63:0] mask, full;
    logic [31:0] held_sum;
    logic        held_cout;
    w    = wd(sel);
    mask = (64'd1 << w) - 64'd1;
    full = (64'(av) & mask) + (64'(bv) & mask) + 64'(c);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    chk("idle_done", 64'(done_of(sel)), 64'd0);
    chk("idle_busy", 64'(busy_of(sel)), 64'd0);
    drive(sel, 1'b1, av, bv, c);
    @(negedge clk);
    if (scramble) drive(sel, 1'b0, $urandom, $urandom, 1'($urandom));
    else          drive(sel, 1'b0, av, bv, c);
    start_cnt[sel]++;
    held_sum  = sum_of(sel);
    held_cout = cout_of(sel);
    for (int i = 0; i < w; i++) begin
      chk("run_busy", 64'(busy_of(sel)), 64'd1);
      chk("run_done", 64'(done_of(sel)), 64'd0);
      chk("run_sum_stable", 64'(sum_of(sel)), 64'(held_sum));
      chk("run_cout_stable", 64'(cout_of(sel)), 64'(held_cout));
      @(negedge clk);
    end
    chk("done_strobe", 64'(done_of(sel)), 64'd1);
    chk("done_busy", 64'(busy_of(sel)), 64'd0);
    chk("sum", 64'(sum_of(sel)), full & mask);
    chk("cout", 64'(cout_of(sel)), 64'(full[w]));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_busy", 64'(busy_of(s)), 64'd0);
      chk("rst_done", 64'(done_of(s)), 64'd0);
      chk("rst_sum",  64'(sum_of(s)),  64'd0);
      chk("rst_cout", 64'(cout_of(s)), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed WIDTH=8 operations; some change inputs mid-run.
    run_op(0, 32'h00, 32'h00, 1'b0, 1'b0, 0);
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b1, 0);
    run_op(0, 32'hA5, 32'h5A, 1'b1, 1'b1, 1);
    run_op(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 0);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    drive(0, 1'b1, 32'h01, 32'h01, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("b2b_done", 64'(done_of(0)), 64'((c % 10) == 8));
      chk("b2b_busy", 64'(busy_of(0)), 64'((c % 10) < 8));
      if ((c % 10) == 8) begin
        start_cnt[0]++;
        chk("b2b_sum",  64'(sum_of(0)),  64'h02);
        chk("b2b_cout", 64'(cout_of(0)), 64'd0);
      end
      if (c == 29) drive(0, 1'b0, 32'h01, 32'h01, 1'b0);
    end

    // Asynchronous reset in the middle of RUN aborts the operation.
    run_op(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 0);
    @(negedge clk);
    drive(0, 1'b1, 32'h80, 32'h80, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h80, 32'h80, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 64'(busy_of(0)), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_of(0)), 64'd0);
    chk("abort_done", 64'(done_of(0)), 64'd0);
    chk("abort_sum",  64'(sum_of(0)),  64'd0);
    chk("abort_cout", 64'(cout_of(0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("post_abort_done", 64'(done_of(0)), 64'd0);
      chk("post_abort_busy", 64'(busy_of(0)), 64'd0);
    end

    // WIDTH=1 exhaustive over {a,b,cin}.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] abc;
      abc = 3'(v);
      run_op(1, 32'(abc[2]), 32'(abc[1]), abc[0], 1'b0, 0);
    end

    // WIDTH=16 randomized operations with mid-run input scrambling.
    for (int n = 0; n < 1000; n++) begin
      run_op(2, $urandom, $urandom, 1'($urandom), 1'b1, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) chk("done_count", 64'(done_cnt[s]), 64'(start_cnt[s]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
